// File: rtl/uart_tx_framer.sv
// uart_tx_framer: frames one byte as start + 8 data bits (LSB first) + optional parity + stop bit(s),
// advancing one bit per baud_tick.
// Ports:
//   clk_in      system clock, all registers on its rising edge
//   rst         synchronous active-high reset, aborts any frame in progress
//   baud_tick   single-cycle pulse once per bit period
//   data_in     byte to transmit, captured on data_valid && data_ready
//   data_valid  data_in holds a byte offered for transmission
//   data_ready  high in IDLE only
//   tx          registered serial line, idle high
//   busy        high whenever not IDLE
//   frame_done  one-cycle pulse in the cycle whose tick ends the last stop bit
module uart_tx_framer #(
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic       clk_in,
    input  logic       rst,
    input  logic       baud_tick,
    input  logic [7:0] data_in,
    input  logic       data_valid,
    output logic       data_ready,
    output logic       tx,
    output logic       busy,
    output logic       frame_done
);
    typedef enum logic [2:0] {IDLE, WAIT, START, DATA, PAR, STOP} state_t;
    state_t     state_q, state_d;
    logic [7:0] shreg_q, shreg_d;
    logic [2:0] bit_idx_q, bit_idx_d;
    logic       stop_cnt_q, stop_cnt_d;
    logic       tx_q, tx_d;
    logic       last_stop;
    logic       par_bit;
    assign last_stop = stop_cnt_q == 1'(STOP_BITS - 1);
    assign par_bit   = (^shreg_q) ^ (PARITY == 2);
    always_ff @(posedge clk_in) begin
        if (rst) begin
            state_q    <= IDLE;
            shreg_q    <= '0;
            bit_idx_q  <= '0;
            stop_cnt_q <= 1'b0;
            tx_q       <= 1'b1;
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            bit_idx_q  <= bit_idx_d;
            stop_cnt_q <= stop_cnt_d;
            tx_q       <= tx_d;
        end
    end
    // The shift register is only loaded at accept; data bits are picked out by
    // index so the captured byte stays intact for the parity computation.
    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        bit_idx_d  = bit_idx_q;
        stop_cnt_d = stop_cnt_q;
        tx_d       = tx_q;
        case (state_q)
            IDLE: if (data_valid) begin
                state_d = WAIT;
                shreg_d = data_in;
            end
            WAIT: if (baud_tick) begin
                state_d = START;
                tx_d    = 1'b0;
            end
            START: if (baud_tick) begin
                state_d   = DATA;
                tx_d      = shreg_q[0];
                bit_idx_d = '0;
            end
            DATA: if (baud_tick) begin
                if (bit_idx_q == 3'd7) begin
                    state_d    = (PARITY != 0) ? PAR : STOP;
                    tx_d       = (PARITY != 0) ? par_bit : 1'b1;
                    stop_cnt_d = 1'b0;
                end else begin
                    bit_idx_d = bit_idx_q + 3'd1;
                    tx_d      = shreg_q[bit_idx_q + 3'd1];
                end
            end
            PAR: if (baud_tick) begin
                state_d    = STOP;
                tx_d       = 1'b1;
                stop_cnt_d = 1'b0;
            end
            STOP: if (baud_tick) begin
                tx_d = 1'b1;
                if (last_stop) state_d = IDLE;
                else stop_cnt_d = stop_cnt_q + 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end
    // frame_done is decoded from the ending tick so the very next cycle is already IDLE.
    always_comb begin
        data_ready = state_q == IDLE;
        busy       = state_q != IDLE;
        tx         = tx_q;
        frame_done = !rst && baud_tick && state_q == STOP && last_stop;
    end
endmodule

// File: tb/tb_uart_tx_framer.sv
// tb_uart_tx_framer: randomized bench for uart_tx_framer over four parity/stop configurations.
module tb_uart_tx_framer;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick = 1'b0;
    logic [7:0] din [4];
    logic [3:0] dv = '0;
    logic [3:0] rdy, txw, bsy, fd;
    int         checks = 0;
    int         fails = 0;
    always #5 clk = ~clk;
    for (genvar g = 0; g < 4; g++) begin : g_dut
        uart_tx_framer #(
            .PARITY   (g == 1 ? 1 : (g == 2 ? 2 : 0)),
            .STOP_BITS(g == 3 ? 2 : 1)
        ) dut (
            .clk_in    (clk),
            .rst       (rst),
            .baud_tick (tick),
            .data_in   (din[g]),
            .data_valid(dv[g]),
            .data_ready(rdy[g]),
            .tx        (txw[g]),
            .busy      (bsy[g]),
            .frame_done(fd[g])
        );
    end
    function automatic int par_of(input int k);
        return k == 1 ? 1 : (k == 2 ? 2 : 0);
    endfunction
    function automatic int stops_of(input int k);
        return k == 3 ? 2 : 1;
    endfunction
    // Sends one byte on DUT k and follows it tick by tick against the expected bit list.
    // hold keeps data_valid high through the frame (with garbage data) and offers nxt at the end.
    // abort_at >= 0 asserts rst in place of that tick and checks the abort.
    task automatic run_frame(input int k, input logic [7:0] b, input bit tick_acc,
                             input bit hold, input logic [7:0] nxt, input int abort_at);
        logic exp_bits[$];
        logic last;
        int   n, gap;
        exp_bits = {};
        exp_bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) exp_bits.push_back(b[i]);
        if (par_of(k) != 0) exp_bits.push_back(1'(($countones(b) + (par_of(k) == 2 ? 1 : 0)) % 2));
        for (int i = 0; i < stops_of(k); i++) exp_bits.push_back(1'b1);
        n = exp_bits.size();
        dv[k] = 1'b1;
        din[k] = b;
        tick = tick_acc;
        #1;
        checks++;
        if (rdy[k] !== 1'b1) begin fails++; $display("FAIL ready_before_accept dut%0d: got %b want 1", k, rdy[k]); end
        @(negedge clk);
        tick = 1'b0;
        if (!hold) dv[k] = 1'b0;
        checks++;
        if ({txw[k], bsy[k], rdy[k], fd[k]} !== 4'b1100) begin
            fails++; $display("FAIL accepted dut%0d: tx/busy/ready/done=%b%b%b%b want 1100", k, txw[k], bsy[k], rdy[k], fd[k]);
        end
        last = 1'b1;
        for (int j = 0; j <= n; j++) begin
            gap = $urandom_range(0, 3);
            for (int c = 0; c < gap; c++) begin
                din[k] = 8'($urandom);
                if (!hold) dv[k] = 1'($urandom);
                @(negedge clk);
                checks++;
                if ({txw[k], bsy[k], fd[k]} !== {last, 2'b10}) begin
                    fails++; $display("FAIL hold dut%0d tick%0d: tx/busy/done=%b%b%b want %b10", k, j, txw[k], bsy[k], fd[k], last);
                end
            end
            if (j == abort_at) begin
                rst = 1'b1;
                tick = 1'b1;
                dv[k] = 1'b1;
                din[k] = 8'($urandom);
                #1;
                checks++;
                if (fd[k] !== 1'b0) begin fails++; $display("FAIL abort_done dut%0d: got %b want 0", k, fd[k]); end
                @(negedge clk);
                rst = 1'b0;
                tick = 1'b0;
                dv[k] = 1'b0;
                checks++;
                if ({txw[k], bsy[k], rdy[k], fd[k]} !== 4'b1010) begin
                    fails++; $display("FAIL abort dut%0d: tx/busy/ready/done=%b%b%b%b want 1010", k, txw[k], bsy[k], rdy[k], fd[k]);
                end
                for (int c = 0; c < 3; c++) begin
                    tick = (c == 1);
                    #1;
                    checks++;
                    if ({txw[k], fd[k]} !== 2'b10) begin fails++; $display("FAIL after_abort dut%0d: tx/done=%b%b want 10", k, txw[k], fd[k]); end
                    @(negedge clk);
                end
                tick = 1'b0;
                return;
            end
            tick = 1'b1;
            if (j == n) begin
                dv[k] = hold;
                din[k] = hold ? nxt : 8'($urandom);
            end
            #1;
            checks++;
            if (fd[k] !== (j == n)) begin fails++; $display("FAIL frame_done dut%0d tick%0d: got %b want %b", k, j, fd[k], j == n); end
            @(negedge clk);
            tick = 1'b0;
            last = j < n ? exp_bits[j] : 1'b1;
            checks++;
            if ({txw[k], bsy[k], rdy[k]} !== {last, j < n, j == n}) begin
                fails++; $display("FAIL bit dut%0d tick%0d: tx/busy/ready=%b%b%b want %b%b%b", k, j, txw[k], bsy[k], rdy[k], last, j < n, j == n);
            end
        end
    endtask
    task automatic test_reset();
        rst = 1'b1;
        dv = 4'hF;
        for (int c = 0; c < 3; c++) begin
            tick = 1'($urandom);
            for (int k = 0; k < 4; k++) din[k] = 8'($urandom);
            @(negedge clk);
            checks++;
            if ({txw, bsy, fd} !== 12'hF00) begin fails++; $display("FAIL reset: tx=%b busy=%b done=%b want 1111/0000/0000", txw, bsy, fd); end
        end
        rst = 1'b0;
        dv = '0;
        tick = 1'b0;
        #1;
        checks++;
        if (rdy !== 4'hF) begin fails++; $display("FAIL reset_ready: got %b want 1111", rdy); end
        @(negedge clk);
    endtask
    task automatic test_known_bytes();
        for (int k = 0; k < 4; k++) run_frame(k, 8'hA5, 1'b0, 1'b0, 8'h00, -1);
        run_frame(1, 8'h07, 1'b0, 1'b0, 8'h00, -1);
        run_frame(2, 8'h07, 1'b0, 1'b0, 8'h00, -1);
        run_frame(3, 8'h00, 1'b0, 1'b0, 8'h00, -1);
    endtask
    task automatic test_tick_on_accept();
        run_frame(0, 8'h3C, 1'b1, 1'b0, 8'h00, -1);
        run_frame(3, 8'(($urandom)), 1'b1, 1'b0, 8'h00, -1);
    endtask
    task automatic test_back_to_back();
        run_frame(0, 8'h55, 1'b0, 1'b1, 8'hAA, -1);
        run_frame(0, 8'hAA, 1'b0, 1'b0, 8'h00, -1);
        run_frame(2, 8'h55, 1'b0, 1'b1, 8'hAA, -1);
        run_frame(2, 8'hAA, 1'b0, 1'b0, 8'h00, -1);
    endtask
    task automatic test_reset_mid_frame();
        run_frame(0, 8'hF0, 1'b0, 1'b0, 8'h00, 5);
        run_frame(0, 8'h96, 1'b0, 1'b0, 8'h00, -1);
        run_frame(3, 8'h81, 1'b0, 1'b0, 8'h00, 11);
        run_frame(3, 8'h4E, 1'b0, 1'b0, 8'h00, -1);
    endtask
    task automatic test_random();
        for (int i = 0; i < 12; i++)
            run_frame(int'($urandom_range(0, 3)), 8'($urandom), 1'($urandom), 1'b0, 8'h00, -1);
    endtask
    initial begin
        for (int k = 0; k < 4; k++) din[k] = '0;
        test_reset();
        test_known_bytes();
        test_tick_on_accept();
        test_back_to_back();
        test_reset_mid_frame();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
